// File: rtl/word_serializer_if.sv
// rtl/word_serializer_if.sv - parallel-word in / serial-bit out handshake bundle
interface word_serializer_if #(
  parameter int WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_msb_first;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_bit;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_first;
  logic                  out_last;
  logic                  busy;

  modport master (
    output in_data, in_msb_first, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_first, out_last, busy
  );

  modport slave (
    input  in_data, in_msb_first, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_first, out_last, busy
  );
endinterface

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - shifts a parallel word out one bit per transfer, LSB or MSB first
module word_serializer #(
  parameter int WORD_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  word_serializer_if.slave  bus
);
  localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic [WORD_WIDTH-1:0] rev_data;
  logic                  shifting;
  logic                  in_xfer;
  logic                  out_xfer;

  // MSB-first words are stored reversed so the datapath always emits bit 0
  always_comb begin
    rev_data = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      rev_data[i] = bus.in_data[WORD_WIDTH-1-i];
    end
  end

  assign shifting      = (state == SHIFT);
  assign bus.out_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.out_bit   = shifting & sreg[0];
  assign bus.out_first = shifting & (cnt == '0);
  assign bus.out_last  = shifting & (cnt == LAST_IDX);

  // Refill in the same cycle the last bit leaves keeps words gapless
  assign bus.in_ready = ~reset & (~shifting | (bus.out_last & bus.out_ready));
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (in_xfer) begin
      sreg  <= bus.in_msb_first ? rev_data : bus.in_data;
      cnt   <= '0;
      state <= SHIFT;
    end else if (out_xfer) begin
      if (bus.out_last) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else begin
        sreg <= {1'b0, sreg[WORD_WIDTH-1:1]};
        cnt  <= cnt + CW'(1);
      end
    end
  end
endmodule
